// File: rtl/fifo_sync_param_if.sv
// Handshake bundle between a producer/consumer pair and fifo_sync_param.
// The master side drives requests and data; the FIFO (slave) returns data, status and errors.
interface fifo_sync_param_if #(
  parameter int WID = 8,
  parameter int DEP = 16
);
  localparam int AW = $clog2(DEP);

  logic [WID-1:0] din;
  logic           wen;
  logic           ren;
  logic           clr_err;
  logic [WID-1:0] dout;
  logic           dval;
  logic           full;
  logic           emp;
  logic           afull;
  logic           aemp;
  logic [AW:0]    cnt;
  logic           ovf;
  logic           udf;

  modport master (
    output din, wen, ren, clr_err,
    input  dout, dval, full, emp, afull, aemp, cnt, ovf, udf
  );

  modport slave (
    input  din, wen, ren, clr_err,
    output dout, dval, full, emp, afull, aemp, cnt, ovf, udf
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky ovf/udf; data readable one edge after write,
// dout/dval registered one edge after an accepted read; writes when full and reads when empty are dropped and flagged.
module fifo_sync_param #(
  parameter int WID      = 8,
  parameter int DEP      = 16,
  parameter int AFULL_TH = DEP - 2,
  parameter int AEMP_TH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sync_param_if.slave  bus
);
  localparam int AW = $clog2(DEP);

  localparam logic [AW:0]   DEP_V   = DEP[AW:0];
  localparam logic [AW:0]   AFULL_V = AFULL_TH[AW:0];
  localparam logic [AW:0]   AEMP_V  = AEMP_TH[AW:0];
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PT_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WID-1:0] mem [DEP];
  logic [AW-1:0]  wpt;
  logic [AW-1:0]  rpt;
  logic [AW:0]    cnt_q;
  logic [WID-1:0] dout_q;
  logic           dval_q;
  logic           ovf_q;
  logic           udf_q;
  logic           full_w;
  logic           emp_w;
  logic           wr_ok;
  logic           rd_ok;

  // Status comes only from registered occupancy, never from this cycle's requests.
  assign full_w = (cnt_q == DEP_V);
  assign emp_w  = (cnt_q == '0);
  assign wr_ok  = bus.wen && !full_w;
  assign rd_ok  = bus.ren && !emp_w;

  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      mem[wpt] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wpt    <= '0;
      rpt    <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      dval_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wpt <= wpt + PT_ONE;
      end
      if (rd_ok) begin
        rpt    <= rpt + PT_ONE;
        dout_q <= mem[rpt];
      end
      dval_q <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      // A new error on the same edge as clr_err keeps the flag set.
      if (bus.wen && full_w) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end
      if (bus.ren && emp_w) begin
        udf_q <= 1'b1;
      end else if (bus.clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.dval  = dval_q;
  assign bus.cnt   = cnt_q;
  assign bus.full  = full_w;
  assign bus.emp   = emp_w;
  assign bus.afull = (cnt_q >= AFULL_V);
  assign bus.aemp  = (cnt_q <= AEMP_V);
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param at WID=8, DEP=4, AFULL_TH=3, AEMP_TH=1.
// Expected words are queued on accepted writes and popped whenever the DUT strobes dval.
module tb_fifo_sync_param;
  localparam int WID = 8;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_sync_param_if #(.WID(WID), .DEP(DEP)) bus ();

  fifo_sync_param #(
    .WID(WID), .DEP(DEP), .AFULL_TH(3), .AEMP_TH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  int         cnt_m;
  logic       ovf_m;
  logic       udf_m;
  logic       dval_m;
  logic [7:0] last_dout;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_d;
    chk("cnt",   32'(bus.cnt),   32'(cnt_m));
    chk("full",  32'(bus.full),  32'(cnt_m == DEP));
    chk("emp",   32'(bus.emp),   32'(cnt_m == 0));
    chk("afull", 32'(bus.afull), 32'(cnt_m >= 3));
    chk("aemp",  32'(bus.aemp),  32'(cnt_m <= 1));
    chk("ovf",   32'(bus.ovf),   32'(ovf_m));
    chk("udf",   32'(bus.udf),   32'(udf_m));
    chk("dval",  32'(bus.dval),  32'(dval_m));
    if (bus.dval === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underrun", 32'(sb.size()), 32'd1);
      end else begin
        exp_d = sb.pop_front();
        chk("dout", 32'(bus.dout), 32'(exp_d));
        last_dout = exp_d;
      end
    end else begin
      chk("dout_hold", 32'(bus.dout), 32'(last_dout));
    end
  endtask

  // One clock: drive requests, advance the reference model at the edge, then check.
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic c, input logic rs);
    logic wa;
    logic ra;
    bus.wen = w;
    bus.ren = r;
    bus.din = d;
    bus.clr_err = c;
    rst = rs;
    @(posedge clk);
    if (!rs) begin
      cnt_m = 0;
      ovf_m = 1'b0;
      udf_m = 1'b0;
      dval_m = 1'b0;
      last_dout = 8'h00;
      sb.delete();
    end else begin
      wa = w && (cnt_m < DEP);
      ra = r && (cnt_m > 0);
      if (w && cnt_m == DEP) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
      if (r && cnt_m == 0) udf_m = 1'b1;
      else if (c) udf_m = 1'b0;
      if (wa) sb.push_back(d);
      cnt_m = cnt_m + int'(wa) - int'(ra);
      dval_m = ra;
    end
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b1);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic c);
    step(1'b0, 1'b0, 8'h00, c, 1'b1);
  endtask

  initial begin
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    bus.din = '0;
    bus.clr_err = 1'b0;
    cnt_m = 0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
    dval_m = 1'b0;
    last_dout = 8'h00;

    // Reset held with both requests active.
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);

    // Fill and drain.
    for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i));
    chk("filled_cnt", 32'(bus.cnt), 32'd4);
    for (int i = 0; i < 4; i++) rd();
    chk("drained_emp", 32'(bus.emp), 32'd1);

    // Overflow: rejected write leaves contents intact.
    for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i));
    wr(8'h55);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    chk("ovf_clr", 32'(bus.ovf), 32'd0);
    for (int i = 0; i < 4; i++) rd();

    // Underflow with simultaneous write.
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("udf_cnt", 32'(bus.cnt), 32'd1);
    rd();
    chk("udf_dout", 32'(bus.dout), 32'h77);
    idle(1'b1);

    // Steady stream at cnt=2, pointers wrap more than twice.
    wr(8'h20);
    wr(8'h21);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
    chk("stream_cnt", 32'(bus.cnt), 32'd2);
    rd();
    rd();
    rd();
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("udf_set_wins", 32'(bus.udf), 32'd1);
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
    wr(8'h99);
    step(1'b1, 1'b0, 8'h9A, 1'b1, 1'b1);
    chk("ovf_set_wins", 32'(bus.ovf), 32'd1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) rd();

    // Reset mid-stream at cnt=3.
    for (int i = 0; i < 3; i++) wr(8'hD0 + 8'(i));
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("mid_rst_cnt", 32'(bus.cnt), 32'd0);
    wr(8'h3C);
    rd();
    chk("post_rst_dout", 32'(bus.dout), 32'h3C);
    idle(1'b0);
    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
